// File: rtl/clk_gen_tune_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gen_tune_ctrl
// Successive-approximation tuning controller for the ring-oscillator clock
// generator. Drives the loop-length select, counts synchronized oscillator
// edges over a fixed window, and binary-searches (MSB first) for the largest
// select whose edge count still reaches the programmed target.
//
// Ports:
//   clk         system clock, all logic rising-edge
//   reset       asynchronous, active-high reset
//   start       begin a search (honoured only in IDLE or DONE)
//   target      minimum edge count per window, latched on accepted start
//   osc_div     divided oscillator output, asynchronous to clk
//   sel         loop-length select to the oscillator
//   busy        high while a search is in progress
//   done        high from search completion until the next accepted start
//   lock        valid with done; 1 when the final select met target
//   meas_count  edge count of the most recently completed window
// ---------------------------------------------------------------------------
module clk_gen_tune_ctrl #(
    parameter int SEL_W  = 5,
    parameter int CNT_W  = 12,
    parameter int WINDOW = 1024,
    parameter int SETTLE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             osc_div,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic             lock,
    output logic [CNT_W-1:0] meas_count
);

    localparam int BIT_W   = (SEL_W > 1) ? $clog2(SEL_W) : 1;
    localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [SEL_W-1:0] SEL_INIT = SEL_W'(1) << (SEL_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t             state_q,  state_d;
    logic [TMR_W-1:0]   timer_q,  timer_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [SEL_W-1:0]   sel_q,    sel_d;
    logic [BIT_W-1:0]   bit_q,    bit_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic               pend_q,   pend_d;
    logic [CNT_W-1:0]   meas_q,   meas_d;
    logic               sync1_q, sync2_q, sync3_q;
    logic               edge_det;

    // Two flops resolve metastability; the third only serves the edge detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= osc_div;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign edge_det = sync2_q & ~sync3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            bit_q    <= '0;
            target_q <= '0;
            pend_q   <= 1'b0;
            meas_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            bit_q    <= bit_d;
            target_q <= target_d;
            pend_q   <= pend_d;
            meas_q   <= meas_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        bit_d    = bit_q;
        target_d = target_q;
        pend_d   = pend_q;
        meas_d   = meas_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    target_d = target;
                    sel_d    = SEL_INIT;
                    bit_d    = BIT_W'(SEL_W - 1);
                    pend_d   = 1'b0;
                    timer_d  = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // Edges seen while the oscillator settles are not counted.
                if (timer_q == TMR_W'(SETTLE - 1)) begin
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = S_MEASURE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_MEASURE: begin
                // Saturating count: a very fast setting must never wrap to a
                // small value and look like a failing trial.
                if (edge_det && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (timer_q == TMR_W'(WINDOW - 1)) begin
                    timer_d = '0;
                    state_d = S_DECIDE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_DECIDE: begin
                meas_d = cnt_q;
                if (cnt_q >= target_q) begin
                    pend_d = 1'b1;
                end else begin
                    sel_d[bit_q] = 1'b0;
                end
                if (bit_q != '0) begin
                    sel_d[bit_q - BIT_W'(1)] = 1'b1;
                    bit_d   = bit_q - BIT_W'(1);
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sel        = sel_q;
    assign busy       = (state_q == S_SETTLE) || (state_q == S_MEASURE) ||
                        (state_q == S_DECIDE);
    assign done       = (state_q == S_DONE);
    assign lock       = (state_q == S_DONE) && pend_q;
    assign meas_count = meas_q;

endmodule
